// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
//   ADDR_W / DATA_W : register address and data widths of the 32x32 file
//   NUM_REGS        : number of architectural registers
//   ZERO_REG        : hard-wired zero register, never written
//   wq_entry_t      : one pending write {addr, data}
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/wq_fwd_match.sv
// Forwarding lookup over the pending-write queue.
//   entries : queue storage, indexed by physical slot
//   valid   : per-slot occupancy mask
//   head    : slot of the oldest entry
//   addr    : lookup register address
//   hit     : some valid entry targets addr (never for the zero register)
//   data    : value of the newest matching entry, else 0
module wq_fwd_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wq_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [ADDR_W-1:0]            addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest; a later match overwrites an earlier one, so the
    // entry closest to the tail wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (addr != ZERO_REG) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write queue feeding the register file write port.
//   clk, rst                 : clock, synchronous active-high reset
//   wb_valid/wb_ready        : writeback request handshake (ready = not full)
//   wb_addr, wb_data         : writeback destination and value
//   drain_en                 : register file accepts a write this cycle
//   RegWrite                 : write strobe (head entry committed on this edge)
//   Register_Write_Adress    : head entry address, 0 when empty
//   Write_Data               : head entry data, 0 when empty
//   fwd_addr_a/b             : operand lookup addresses
//   fwd_hit_a/b, fwd_data_a/b: newest pending value for each lookup
//   count, empty, full       : occupancy status
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [ADDR_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic                        drain_en,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           Register_Write_Adress,
    output logic [DATA_W-1:0]           Write_Data,
    input  logic [ADDR_W-1:0]           fwd_addr_a,
    input  logic [ADDR_W-1:0]           fwd_addr_b,
    output logic                        fwd_hit_a,
    output logic                        fwd_hit_b,
    output logic [DATA_W-1:0]           fwd_data_a,
    output logic [DATA_W-1:0]           fwd_data_b,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty,
    output logic                        full
);

    import regfile_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_fire;
    logic             push_store;
    logic             pop;
    wq_entry_t        head_entry;
    logic [DEPTH-1:0] valid_mask;
    logic [PTR_W-1:0] offset;

    // Status is derived only from registered occupancy, so wb_ready has no
    // combinational path from drain_en.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign wb_ready = !full;
    assign count    = count_q;

    // Writes to the zero register complete the handshake but are dropped.
    assign push_fire  = wb_valid && wb_ready;
    assign push_store = push_fire && (wb_addr != ZERO_REG);

    assign head_entry            = mem_q[head_q];
    assign RegWrite              = !empty && drain_en && !rst;
    assign pop                   = RegWrite;
    assign Register_Write_Adress = empty ? '0 : head_entry.addr;
    assign Write_Data            = empty ? '0 : head_entry.data;

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push_store);
        count_d = count_q + CNT_W'(push_store) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_store && !rst) begin
            mem_q[tail_q].addr <= wb_addr;
            mem_q[tail_q].data <= wb_data;
        end
    end

    // A slot is occupied when its distance from head is below count.
    always_comb begin
        valid_mask = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = PTR_W'(i) - head_q;
            valid_mask[i] = (CNT_W'(offset) < count_q);
        end
    end

    wq_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .entries (mem_q),
        .valid   (valid_mask),
        .head    (head_q),
        .addr    (fwd_addr_a),
        .hit     (fwd_hit_a),
        .data    (fwd_data_a)
    );

    wq_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .entries (mem_q),
        .valid   (valid_mask),
        .head    (head_q),
        .addr    (fwd_addr_b),
        .hit     (fwd_hit_b),
        .data    (fwd_data_b)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        drain_en;
    logic        RegWrite;
    logic [4:0]  Register_Write_Adress;
    logic [31:0] Write_Data;
    logic [4:0]  fwd_addr_a;
    logic [4:0]  fwd_addr_b;
    logic        fwd_hit_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_a;
    logic [31:0] fwd_data_b;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .wb_valid              (wb_valid),
        .wb_ready              (wb_ready),
        .wb_addr               (wb_addr),
        .wb_data               (wb_data),
        .drain_en              (drain_en),
        .RegWrite              (RegWrite),
        .Register_Write_Adress (Register_Write_Adress),
        .Write_Data            (Write_Data),
        .fwd_addr_a            (fwd_addr_a),
        .fwd_addr_b            (fwd_addr_b),
        .fwd_hit_a             (fwd_hit_a),
        .fwd_hit_b             (fwd_hit_b),
        .fwd_data_a            (fwd_data_a),
        .fwd_data_b            (fwd_data_b),
        .count                 (count),
        .empty                 (empty),
        .full                  (full)
    );

    always #5 clk = ~clk;

    int   vec_cnt = 0;
    int   mis_cnt = 0;
    bit   chk_en  = 1'b0;
    ent_t mq[$];     // pending writes as the reference sees them
    ent_t exp_q[$];  // expected commit order, consumed by the monitor

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == a) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    // Reference: pop the oldest if draining, accept while not full,
    // drop zero-register writes, flush on reset.
    always @(posedge clk) begin
        ent_t e;
        bit   acc;
        if (rst) begin
            mq.delete();
            exp_q.delete();
        end else begin
            acc = wb_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && drain_en) void'(mq.pop_front());
            if (acc && wb_addr != 5'd0) begin
                e.a = wb_addr;
                e.d = wb_data;
                mq.push_back(e);
                exp_q.push_back(e);
            end
        end
    end

    // Status and forwarding checks against the reference state.
    always @(negedge clk) begin
        int          n;
        logic        h;
        logic [31:0] d;
        if (chk_en) begin
            n = mq.size();
            chk("count",    32'(count),    32'(n));
            chk("empty",    32'(empty),    32'(n == 0));
            chk("full",     32'(full),     32'(n == DEPTH));
            chk("wb_ready", 32'(wb_ready), 32'(n < DEPTH));
            chk("RegWrite", 32'(RegWrite), 32'(n > 0 && drain_en && !rst));
            if (n == 0) begin
                chk("idle_addr", 32'(Register_Write_Adress), 32'd0);
                chk("idle_data", Write_Data, 32'd0);
            end
            model_fwd(fwd_addr_a, h, d);
            chk("fwd_hit_a",  32'(fwd_hit_a), 32'(h));
            chk("fwd_data_a", fwd_data_a, d);
            model_fwd(fwd_addr_b, h, d);
            chk("fwd_hit_b",  32'(fwd_hit_b), 32'(h));
            chk("fwd_data_b", fwd_data_b, d);
        end
    end

    // Commit monitor: every write strobe must match the next expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (chk_en && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 32'(RegWrite), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_addr", 32'(Register_Write_Adress), 32'(e.a));
                chk("commit_data", Write_Data, e.d);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic de, input logic [4:0] fa, input logic [4:0] fb,
                       input logic r);
        wb_valid   = v;
        wb_addr    = a;
        wb_data    = d;
        drain_en   = de;
        fwd_addr_a = fa;
        fwd_addr_b = fb;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        drain_en = 1'b0; fwd_addr_a = '0; fwd_addr_b = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset then idle
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1, 3, 0, 0);

        // Reset while three entries are queued and drain is requested
        cyc(1, 3, 32'h1111_0003, 0, 0, 0, 0);
        cyc(1, 5, 32'h1111_0005, 0, 0, 0, 0);
        cyc(1, 9, 32'h1111_0009, 0, 3, 5, 0);
        cyc(0, 0, 0, 1, 3, 9, 1);
        cyc(0, 0, 0, 1, 3, 9, 0);

        // Duplicate addresses, newest-wins forwarding, in-order drain
        cyc(1, 3, 32'hAAAA_0001, 0, 3, 7, 0);
        cyc(1, 7, 32'h0000_0007, 0, 3, 7, 0);
        cyc(1, 3, 32'hBBBB_0002, 0, 3, 7, 0);
        cyc(0, 0, 0, 0, 3, 7, 0);
        repeat (4) cyc(0, 0, 0, 1, 3, 7, 0);

        // Fill to DEPTH, refused 5th push, single drain cycle
        for (int i = 1; i <= DEPTH; i++) cyc(1, 5'(i), 32'h5000_0000 + 32'(i), 0, 5'(i), 2, 0);
        cyc(1, 5, 32'h5000_0005, 0, 1, 4, 0);
        cyc(1, 5, 32'h5000_0005, 1, 1, 4, 0);
        cyc(0, 0, 0, 0, 1, 2, 0);
        repeat (4) cyc(0, 0, 0, 1, 4, 5, 0);

        // Zero-register write is accepted but dropped
        cyc(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Continuous push while draining: pointers wrap repeatedly
        for (int i = 1; i <= 8; i++) cyc(1, 5'(i), 32'hC000_0000 + 32'(i), 1, 5'(i), 5'(i - 1), 0);
        repeat (2) cyc(0, 0, 0, 1, 8, 0, 0);

        // Randomized traffic with small address range to force duplicates
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), a, $urandom,
                ($urandom_range(0, 2) != 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 63) == 0));
        end

        // Drain whatever remains, bounded
        for (int i = 0; i < 20 && mq.size() > 0; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
